// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns byte/half/word loads and stores into word-wide RAM
// read/write cycles, with load extension and read-modify-write for narrow stores.
module load_store_unit #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [DWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DWIDTH-1:0] rdata,
  output logic [DWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wr_data,
  output logic              mem_rdEn,
  output logic              mem_wrEn,
  input  logic [DWIDTH-1:0] mem_rd_data
);

  typedef enum logic [2:0] {IDLE, RD, RDWAIT, WR, ERR} state_t;

  state_t state, state_next;

  // Request fields kept for the later phases of the access.
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;

  logic              access_ok;
  logic              is_sw;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DWIDTH-1:0] load_ext;
  logic [DWIDTH-1:0] merged;

  logic              busy_n, done_n, err_n, rd_en_n, wr_en_n;
  logic [DWIDTH-1:0] rdata_n, mem_addr_n, mem_wr_data_n;

  // Width/sign code legality combined with natural alignment.
  always_comb begin
    case (funct3)
      3'd0:    access_ok = 1'b1;
      3'd1:    access_ok = ~addr[0];
      3'd2:    access_ok = (addr[1:0] == 2'b00);
      3'd4:    access_ok = ~we;
      3'd5:    access_ok = ~we & ~addr[0];
      default: access_ok = 1'b0;
    endcase
  end

  assign is_sw = we && (funct3 == 3'd2);

  always_comb begin
    case (lane_q)
      2'd0:    ld_byte = mem_rd_data[7:0];
      2'd1:    ld_byte = mem_rd_data[15:8];
      2'd2:    ld_byte = mem_rd_data[23:16];
      default: ld_byte = mem_rd_data[31:24];
    endcase
    ld_half = lane_q[1] ? mem_rd_data[31:16] : mem_rd_data[15:0];
  end

  always_comb begin
    case (funct3_q)
      3'd0:    load_ext = {{(DWIDTH-8){ld_byte[7]}}, ld_byte};
      3'd1:    load_ext = {{(DWIDTH-16){ld_half[15]}}, ld_half};
      3'd4:    load_ext = {{(DWIDTH-8){1'b0}}, ld_byte};
      3'd5:    load_ext = {{(DWIDTH-16){1'b0}}, ld_half};
      default: load_ext = mem_rd_data;
    endcase
  end

  // Narrow store: replace only the addressed lane of the word just read.
  always_comb begin
    merged = mem_rd_data;
    if (funct3_q[1:0] == 2'd0) begin
      case (lane_q)
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (lane_q[1]) begin
      merged[31:16] = wdata_q;
    end else begin
      merged[15:0] = wdata_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (!access_ok) state_next = ERR;
          else if (is_sw) state_next = WR;
          else            state_next = RD;
        end
      end
      RD:      state_next = RDWAIT;
      RDWAIT:  state_next = we_q ? WR : IDLE;
      WR:      state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs; enables follow the state being entered.
  always_comb begin
    busy_n        = (state_next != IDLE);
    rd_en_n       = (state_next == RD);
    wr_en_n       = (state_next == WR);
    done_n        = 1'b0;
    err_n         = err;
    rdata_n       = rdata;
    mem_addr_n    = mem_addr;
    mem_wr_data_n = mem_wr_data;
    case (state)
      IDLE: begin
        if (req) begin
          mem_addr_n = {addr[DWIDTH-1:2], 2'b00};
          if (access_ok && is_sw) mem_wr_data_n = wdata;
        end
      end
      RDWAIT: begin
        if (we_q) begin
          mem_wr_data_n = merged;
        end else begin
          done_n  = 1'b1;
          err_n   = 1'b0;
          rdata_n = load_ext;
        end
      end
      WR: begin
        done_n = 1'b1;
        err_n  = 1'b0;
      end
      ERR: begin
        done_n  = 1'b1;
        err_n   = 1'b1;
        rdata_n = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      rdata       <= '0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      mem_rdEn    <= 1'b0;
      mem_wrEn    <= 1'b0;
      we_q        <= 1'b0;
      funct3_q    <= 3'd0;
      lane_q      <= 2'd0;
      wdata_q     <= 16'd0;
    end else begin
      busy        <= busy_n;
      done        <= done_n;
      err         <= err_n;
      rdata       <= rdata_n;
      mem_addr    <= mem_addr_n;
      mem_wr_data <= mem_wr_data_n;
      mem_rdEn    <= rd_en_n;
      mem_wrEn    <= wr_en_n;
      if (state == IDLE && req) begin
        we_q     <= we;
        funct3_q <= funct3;
        lane_q   <= addr[1:0];
        wdata_q  <= wdata[15:0];
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word RAM beside the DUT, byte-addressed reference memory,
// directed scenarios followed by randomized loads/stores.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, err, mem_rdEn, mem_wrEn;
  logic [31:0] rdata, mem_addr, mem_wr_data;
  logic [31:0] mem_rd_data = '0;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.DWIDTH(32)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rdEn(mem_rdEn),
    .mem_wrEn(mem_wrEn), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  // Word RAM: one-cycle read latency, writes only on mem_wrEn, plus a bench preload port.
  logic [31:0] ram [0:63];
  logic        pre_we = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) ram[pre_idx] <= pre_data;
    else if (mem_wrEn) ram[mem_addr[7:2]] <= mem_wr_data;
    if (mem_rdEn) mem_rd_data <= ram[mem_addr[7:2]];
  end

  int rd_cnt = 0;
  int wr_cnt = 0;
  bit both_hi = 1'b0;
  always @(posedge clk) begin
    if (mem_rdEn) rd_cnt++;
    if (mem_wrEn) wr_cnt++;
    if (mem_rdEn && mem_wrEn) both_hi = 1'b1;
  end

  // Reference model: byte-addressed little-endian memory and last load result.
  logic [7:0]  mbytes [0:255];
  logic [31:0] last_rdata = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input bit w, input logic [2:0] f, input logic [31:0] a);
    int size;
    if (w) begin
      if (f > 3'd2) return 1'b0;
    end else if (!(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) begin
      return 1'b0;
    end
    size = 1 << f[1:0];
    return (a % size) == 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f, input logic [31:0] a);
    int n;
    logic [31:0] v;
    logic [31:0] ones;
    n = 1 << f[1:0];
    v = '0;
    ones = '1;
    for (int i = 0; i < n; i++) v = v | (32'(mbytes[a + i]) << (8 * i));
    if (!f[2] && n < 4 && v[8 * n - 1]) v = v | (ones << (8 * n));
    return v;
  endfunction

  task automatic model_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd);
    int n;
    n = 1 << f[1:0];
    for (int i = 0; i < n; i++) mbytes[a + i] = wd[8 * i +: 8];
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = a[7:2]; pre_data = v;
    @(posedge clk); #1;
    pre_we = 1'b0;
    for (int i = 0; i < 4; i++) mbytes[{a[7:2], 2'b00} + i] = v[8 * i +: 8];
  endtask

  // One access from request to done, checked against the reference model.
  task automatic do_op(input bit w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] wd, input string tag);
    int r0, w0, exp_lat, lat;
    bit ok, got;
    logic [31:0] exp_rd;
    r0 = rd_cnt; w0 = wr_cnt;
    ok = legal(w, f, a);
    exp_lat = !ok ? 1 : (!w ? 2 : (f == 3'd2 ? 1 : 3));
    exp_rd = !ok ? 32'h0 : (!w ? model_load(f, a) : last_rdata);
    @(negedge clk);
    req = 1'b1; we = w; funct3 = f; addr = a; wdata = wd;
    @(posedge clk); #1;
    req = 1'b0; we = 1'($urandom); funct3 = 3'($urandom);
    addr = $urandom; wdata = $urandom;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    got = 1'b0; lat = 0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(posedge clk); #1;
      if (done) begin got = 1'b1; lat = k; end
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_rdata"}, rdata, exp_rd);
      check({tag, "_err"}, 32'(err), 32'(!ok));
      check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      check({tag, "_mem_addr"}, mem_addr, {a[31:2], 2'b00});
      check({tag, "_reads"}, rd_cnt - r0, (ok && (!w || f != 3'd2)) ? 1 : 0);
      check({tag, "_writes"}, wr_cnt - w0, (ok && w) ? 1 : 0);
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
    end
    if (ok && w) model_store(f, a, wd);
    last_rdata = exp_rd;
  endtask

  initial begin
    int r0, w0;
    logic [31:0] v, a;
    logic [2:0] f;
    bit w;

    for (int i = 0; i < 64; i++) preload(32'(i * 4), $urandom);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wr_data", mem_wr_data, 32'd0);
    check("rst_rden", 32'(mem_rdEn), 32'd0);
    check("rst_wren", 32'(mem_wrEn), 32'd0);
    rst = 1'b0;

    // Loads with extension
    preload(32'h10, 32'h8899AABB);
    do_op(1'b0, 3'd2, 32'h10, 32'h0, "lw");
    check("lw_value", rdata, 32'h8899AABB);
    do_op(1'b0, 3'd0, 32'h13, 32'h0, "lb");
    check("lb_value", rdata, 32'hFFFFFF88);
    do_op(1'b0, 3'd4, 32'h13, 32'h0, "lbu");
    check("lbu_value", rdata, 32'h00000088);
    do_op(1'b0, 3'd1, 32'h12, 32'h0, "lh");
    check("lh_value", rdata, 32'hFFFF8899);
    do_op(1'b0, 3'd5, 32'h10, 32'h0, "lhu");
    check("lhu_value", rdata, 32'h0000AABB);

    // Byte store read-modify-write
    preload(32'h20, 32'h11223344);
    do_op(1'b1, 3'd0, 32'h21, 32'hDEADBEEF, "sb");
    do_op(1'b0, 3'd2, 32'h20, 32'h0, "sb_lw");
    check("sb_lw_value", rdata, 32'h1122EF44);

    // Illegal / misaligned
    do_op(1'b0, 3'd2, 32'h22, 32'h0, "lw_mis");
    do_op(1'b1, 3'd1, 32'h23, 32'h1234, "sh_mis");
    do_op(1'b1, 3'd4, 32'h24, 32'h5678, "st_f3_4");
    do_op(1'b0, 3'd3, 32'h24, 32'h0, "ld_f3_3");

    // Back-to-back: req held through the SW, LW accepted on the done edge
    r0 = rd_cnt; w0 = wr_cnt;
    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = 3'd2; addr = 32'h30; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    we = 1'b0;
    @(posedge clk); #1;
    check("b2b_sw_done", 32'(done), 32'd1);
    check("b2b_sw_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    req = 1'b0;
    check("b2b_lw_accept", 32'(busy), 32'd1);
    check("b2b_no_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    check("b2b_wait", 32'(done), 32'd0);
    @(posedge clk); #1;
    check("b2b_lw_done", 32'(done), 32'd1);
    check("b2b_lw_rdata", rdata, 32'hCAFEF00D);
    check("b2b_lw_err", 32'(err), 32'd0);
    check("b2b_reads", rd_cnt - r0, 1);
    check("b2b_writes", wr_cnt - w0, 1);
    model_store(3'd2, 32'h30, 32'hCAFEF00D);
    last_rdata = 32'hCAFEF00D;

    // Reset during the RDWAIT of an SH
    v = $urandom;
    preload(32'h40, v);
    w0 = wr_cnt;
    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = 3'd1; addr = 32'h42; wdata = 32'h0000BEEF;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_mid_rden", 32'(mem_rdEn), 32'd0);
    check("rst_mid_wren", 32'(mem_wrEn), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_rdata", rdata, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_rdata = '0;
    @(negedge clk);
    check("rst_mid_busy_after", 32'(busy), 32'd0);
    check("rst_mid_no_write", wr_cnt - w0, 0);
    do_op(1'b0, 3'd2, 32'h40, 32'h0, "rst_mid_lw");
    check("rst_mid_word", rdata, v);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      w = 1'($urandom);
      f = 3'($urandom);
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f[1:0]) - 32'd1);
      do_op(w, f, a, $urandom, "rnd");
    end

    check("never_both_enables", 32'(both_hi), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- CPU-side initiator for the word-wide data RAM.
- Converts RV32I loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into RAM read/write cycles.
- Performs sign/zero extension on loads and read-modify-write for byte/halfword stores, because the RAM only writes full words.
- Sits between the execute stage and the data RAM; the core stalls on busy.

Parameters:
- DWIDTH, 32, data and address width (fixed at 32 for RV32I).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- req  input  1  request strobe, sampled only while busy=0
- we  input  1  1=store, 0=load (captured with req)
- funct3  input  3  RV32I width/sign code (captured with req)
- addr  input  DWIDTH  byte address (captured with req)
- wdata  input  DWIDTH  store data, low bits used for SB/SH (captured with req)
- busy  output  1  high while an access is in flight
- done  output  1  one-cycle completion pulse
- err  output  1  valid with done; misaligned or illegal funct3
- rdata  output  DWIDTH  extended load result, valid with done
- mem_addr  output  DWIDTH  RAM address, always {addr[31:2],2'b00}
- mem_wr_data  output  DWIDTH  RAM write data
- mem_rdEn  output  1  RAM read enable
- mem_wrEn  output  1  RAM write enable
- mem_rd_data  input  DWIDTH  RAM read data, valid one clock after mem_rdEn sampled

Behaviour:
- Reset values: all outputs 0, state IDLE. Reset is asynchronous: mem_rdEn and mem_wrEn drop immediately, and an in-flight access is abandoned with no done pulse.
- All outputs are registered.
- States: IDLE, RD, RDWAIT, WR, ERR. busy = (state != IDLE).
- Request accept: req=1 in IDLE at edge E0 latches we, funct3, addr and wdata. req while busy is ignored (no queueing).
- Legality check at E0:
  - Loads: funct3 ∈ {0,1,2,4,5}.
  - Stores: funct3 ∈ {0,1,2}.
  - Alignment: half needs addr[0]=0; word needs addr[1:0]=0.
  - Illegal or misaligned -> ERR. No RAM enable asserted. done=err=1 at E1, rdata=0, then IDLE.
- Load (legal): E0 -> RD with mem_rdEn=1; E1 -> RDWAIT with mem_rdEn=0; E2 -> done=1 and rdata registered from mem_rd_data, state IDLE. Latency is 2 edges.
- Load byte lane = addr[1:0], little-endian: lane 0 = bits 7:0. Half lane = addr[1]: 0 -> bits 15:0, 1 -> bits 31:16.
- Load extension: LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- SW: E0 -> WR with mem_wrEn=1 and mem_wr_data=wdata; E1 -> done=1, mem_wrEn=0, IDLE. Latency is 1 edge.
- SB/SH (read-modify-write):
  - E0 -> RD (mem_rdEn=1). E1 -> RDWAIT.
  - During RDWAIT, merge mem_rd_data with wdata[7:0] (SB) or wdata[15:0] (SH) into the addressed lane; other lanes are unchanged.
  - E2 -> WR with mem_wr_data=merged word and mem_wrEn=1.
  - E3 -> done=1, IDLE. Latency is 3 edges.
- mem_addr holds the aligned word address from E0 until the next accepted request. The address never changes while an enable is high.
- mem_rdEn and mem_wrEn are never high in the same cycle.
- done is high exactly one cycle. busy=0 during that cycle, so a new req may be sampled on the edge that ends it (back-to-back, no bubble).
- rdata holds its value until the next load completes. It is 0 on error. Stores leave rdata unchanged.
- err is cleared on every done that is not an error.
- Only the write enable commits data: reset during RDWAIT or WR never produces a partial write after reset.

Test Plan:
- LW: RAM word at 0x10 = 0x8899AABB; req LW addr=0x10 -> mem_rdEn for one cycle, done two edges after accept, rdata=0x8899AABB, err=0.
- LB/LBU: same word, addr=0x13 -> LB rdata=0xFFFFFF88, LBU rdata=0x00000088. LH addr=0x12 -> 0xFFFF8899; LHU addr=0x10 -> 0x0000AABB.
- SB: word 0x11223344 at 0x20; SB addr=0x21 wdata=0xDEADBEEF -> one read, then one write of 0x1122EF44, done three edges after accept. A subsequent LW returns 0x1122EF44.
- Misaligned/illegal: LW addr=0x22, SH addr=0x23, and store funct3=4 -> done=err=1 one edge after accept, no mem_rdEn or mem_wrEn pulse, rdata=0.
- Back-to-back: SW 0xCAFEF00D at 0x30, then req held high with LW 0x30 -> LW accepted on the done edge, rdata=0xCAFEF00D. A req issued while busy=1 produces no extra access.
- Reset mid-RMW: assert rst during the RDWAIT of an SH -> enables drop at once, no mem_wrEn, no done. After release busy=0 and the RAM word is unchanged.
